// File: rtl/register_bank.sv
// 16 x 32-bit one-hot addressed register file for the single-bus datapath.
// Optional macro REGBANK_R0_HARDZERO_EN turns R0 into a constant-zero register.
module register_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [NUM_REGS-1:0] RinSignals,
  input  logic [NUM_REGS-1:0] RoutSignals,
  input  logic [DATA_W-1:0]   BusMuxOut,
  output logic [DATA_W-1:0]   BusMuxIn_R,
  output logic [NUM_REGS-1:0] reg_written,
  output logic                rin_err,
  output logic                rout_err
);

  logic [DATA_W-1:0]   store [NUM_REGS];
  logic [NUM_REGS-1:0] wr_mask;
  logic                rin_multi;
  logic                rout_multi;
  logic                rout_one;

  // Clearing the lowest set bit leaves something only when two or more were set.
  function automatic logic multi_hot(input logic [NUM_REGS-1:0] v);
    return (v & (v - NUM_REGS'(1))) != '0;
  endfunction

  assign rin_multi  = multi_hot(RinSignals);
  assign rout_multi = multi_hot(RoutSignals);
  assign rout_one   = (RoutSignals != '0) && !rout_multi;

`ifdef REGBANK_R0_HARDZERO_EN
  assign wr_mask = RinSignals & ~NUM_REGS'(1);
`else
  assign wr_mask = RinSignals;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) store[i] <= '0;
      reg_written <= '0;
      rin_err     <= 1'b0;
      rout_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_mask[i]) store[i] <= BusMuxOut;
      end
      reg_written <= reg_written | wr_mask;
      if (rin_multi)  rin_err  <= 1'b1;
      if (rout_multi) rout_err <= 1'b1;
    end
  end

  // Reads come only from registered state, so a same-cycle write is seen next cycle.
  always_comb begin
    BusMuxIn_R = '0;
    if (rout_one) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (RoutSignals[i]) BusMuxIn_R = store[i];
      end
`ifdef REGBANK_R0_HARDZERO_EN
      if (RoutSignals[0]) BusMuxIn_R = '0;
`endif
    end
  end

endmodule
